staggered_add_sched: RTL and testbench
======================================

# staggered_add_sched

Round-robin scheduler that shares one pipelined `StaggeredAdd` instance between `R` requesters. It accepts add or subtract requests over valid/ready handshakes and issues at most one operation per cycle into the adder. It carries each requester ID through a latency-matched tag pipeline and returns each result to the requester that issued it. The block sits between the client datapaths and the adder; the adder itself is instantiated outside this block.

## Interface
- `N`, 16: operand width; must match the adder.
- `R`, 4: number of requesters, 2..8.
- `LAT`, 4: adder latency in cycles, from the operand register update to a valid `AddS`/`AddCO`. Must be ≥1.
- `Clock`  in  1: single clock, rising edge.
- `ResetN`  in  1: asynchronous, active-low reset.
- `ReqValid`  in  R: per-requester request valid.
- `ReqReady`  out  R: per-requester grant; combinational.
- `ReqA`, `ReqB`  in  R*N: packed operands; requester i uses slice [i*N +: N].
- `ReqCI`  in  R: carry-in, used only when the op is ADD.
- `ReqOp`  in  R: 0 = ADD, 1 = SUB.
- `AddA`, `AddB`  out  N: registered operands driven to the adder.
- `AddCI`  out  1: registered carry-in driven to the adder.
- `AddS`  in  N: adder sum.
- `AddCO`  in  1: adder carry-out.
- `RspValid`  out  R: one-cycle result pulse, one-hot or zero.
- `RspSum`  out  N: result sum, shared by all requesters.
- `RspCarry`  out  1: carry-out for ADD; not-borrow for SUB.
- `Drain`  in  1: when high, no new grants are issued.
- `Idle`  out  1: high when no operation is in flight.

## Operation
- Grant rule:
  - Round-robin over `ReqValid` when `Drain`=0.
  - Search starts at pointer `Ptr`.
  - At most one bit of `ReqReady` is high, and only for a requester whose `ReqValid` is high.
- On a handshake (`ReqValid[i]` and `ReqReady[i]`):
  - `Ptr` ← (i+1) mod R.
  - `AddA` ← A_i.
  - ADD: `AddB` ← B_i and `AddCI` ← CI_i.
  - SUB: `AddB` ← ~B_i and `AddCI` ← 1.
  - Tag {valid=1, id=i} enters stage 0 of the tag pipeline.
- With no handshake, `AddA`/`AddB`/`AddCI` hold their values and a tag with valid=0 enters the pipeline.
- The tag pipeline has `LAT` stages and shifts every cycle; it does not stall, since responses have no backpressure.
- When the tag leaving stage LAT-1 is valid:
  - `RspSum` ← `AddS`.
  - `RspCarry` ← `AddCO`.
  - `RspValid` ← one-hot(id) for one cycle.
- Otherwise `RspValid` ← 0 and `RspSum`/`RspCarry` hold.
- Arithmetic: result is (A + B + CI) mod 2^N, with the carry in `RspCarry`. SUB gives A − B mod 2^N, with `RspCarry`=1 iff A ≥ B (unsigned).
- `Idle` = no valid tag in any stage and no valid response being generated this cycle.
- Requesters must hold `ReqValid` and their operands stable until granted.

## Timing
- Reset values (async assert, sync release):
  - `Ptr`=0; all tags invalid.
  - `AddA`=0, `AddB`=0, `AddCI`=0.
  - `RspValid`=0, `RspSum`=0, `RspCarry`=0.
  - `Idle`=1.
- `ReqReady` is combinational and also 0 during reset.
- Latency: a handshake at edge t updates the adder inputs at edge t. The result is captured at edge t+LAT, and `RspValid` is high in the cycle after edge t+LAT.
- Throughput: one operation per cycle, sustained.
- Back-to-back grants to the same requester are allowed only when it is the only one requesting.
- `Drain` raised in the same cycle as `ReqValid`: no grant that cycle.
- Operations already in flight when `Drain` rises complete normally.
- `Idle` rises LAT+1 cycles after the last grant.
- Reset mid-operation: in-flight results are discarded, with no `RspValid` pulse.
- Pointer wrap: from R-1 to 0.

## Structure
- Shared package `staggered_pkg`:
  - `op_e` enum {OP_ADD, OP_SUB}.
  - `tag_t` struct {valid, id[$clog2(R)-1:0]}.
  - Default `LAT` constant.
- One sub-module, `rr_arbiter` (parameter `R`):
  - Inputs: request vector, enable.
  - Outputs: one-hot grant; pointer update on accept.
- Tag pipeline, operand registers, op decode and response register are kept in the top module.

## Test plan
- Reset, then requester 0 ADD with A=7, B=9, CI=1 → `RspValid`=0001 exactly LAT+1 cycles after the grant, with `RspSum`=17, `RspCarry`=0.
- Requester 2 SUB with A=5, B=9 → `RspSum`=0xFFFC, `RspCarry`=0. Then A=9, B=5 → `RspSum`=4, `RspCarry`=1.
- All four requesters hold `ReqValid` for 8 cycles → grants in order 0,1,2,3,0,1,2,3; responses arrive in the same order, one per cycle, each with the correct ID.
- ADD with A=0xFFFF, B=0x0001, CI=0 → `RspSum`=0, `RspCarry`=1.
- Three grants issued, then `Drain`=1 with requests still pending → no further `ReqReady`. All three responses are delivered, and `Idle` rises LAT+1 cycles after the last grant.
- Assert `ResetN`=0 two cycles after a grant → no `RspValid`, and all outputs are at their reset values immediately. After release, a new request completes normally.
- Random self-check: the bench models the adder as a delay of exactly LAT cycles. Run 10k random ops across all requesters and compare {`RspCarry`,`RspSum`} against the reference sum.

Source files
------------

// File: rtl/staggered_pkg.sv
// Shared types and defaults for the staggered-adder scheduler.
// Tag IDs are sized for the largest supported requester count.
package staggered_pkg;

    localparam int unsigned DEF_N   = 16;
    localparam int unsigned DEF_R   = 4;
    localparam int unsigned DEF_LAT = 4;
    localparam int unsigned MAX_R   = 8;
    localparam int unsigned ID_W    = $clog2(MAX_R);

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/staggered_add_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from a rotating pointer,
// pointer moves past the winner whenever a grant is issued.
module rr_arbiter
    import staggered_pkg::*;
#(
    parameter int unsigned R = DEF_R
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [R-1:0]    i_req,
    input  logic            i_enable,
    output logic [R-1:0]    o_grant,
    output logic [ID_W-1:0] o_grant_id,
    output logic            o_accept
);

    logic [ID_W-1:0] r_ptr;
    logic [ID_W-1:0] w_next_ptr;

    always_comb begin
        int unsigned idx;
        idx        = 0;
        o_grant    = '0;
        o_grant_id = '0;
        o_accept   = 1'b0;
        if (i_enable) begin
            for (int unsigned k = 0; k < R; k++) begin
                idx = (32'(r_ptr) + k) % R;
                if (!o_accept && i_req[idx]) begin
                    o_grant[idx] = 1'b1;
                    o_grant_id   = ID_W'(idx);
                    o_accept     = 1'b1;
                end
            end
        end
    end

    assign w_next_ptr = (o_grant_id == ID_W'(R - 1)) ? '0 : o_grant_id + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (o_accept) begin
            r_ptr <= w_next_ptr;
        end
    end

endmodule

// File: rtl/staggered_add_sched.sv
// Shares one pipelined adder between R requesters; requester IDs ride a
// latency-matched tag pipeline so each result returns to its issuer.
module staggered_add_sched
    import staggered_pkg::*;
#(
    parameter int unsigned N   = DEF_N,
    parameter int unsigned R   = DEF_R,
    parameter int unsigned LAT = DEF_LAT
) (
    input  logic           Clock,
    input  logic           ResetN,
    input  logic [R-1:0]   ReqValid,
    output logic [R-1:0]   ReqReady,
    input  logic [R*N-1:0] ReqA,
    input  logic [R*N-1:0] ReqB,
    input  logic [R-1:0]   ReqCI,
    input  logic [R-1:0]   ReqOp,
    output logic [N-1:0]   AddA,
    output logic [N-1:0]   AddB,
    output logic           AddCI,
    input  logic [N-1:0]   AddS,
    input  logic           AddCO,
    output logic [R-1:0]   RspValid,
    output logic [N-1:0]   RspSum,
    output logic           RspCarry,
    input  logic           Drain,
    output logic           Idle
);

    logic [R-1:0]    w_grant;
    logic [ID_W-1:0] w_grant_id;
    logic            w_accept;
    logic            w_enable;

    logic [N-1:0]    w_sel_a;
    logic [N-1:0]    w_sel_b;
    logic            w_sel_ci;
    op_e             w_sel_op;
    logic [N-1:0]    w_opnd_b;
    logic            w_opnd_ci;

    logic [N-1:0]    r_add_a;
    logic [N-1:0]    r_add_b;
    logic            r_add_ci;

    tag_t            r_tag [LAT];
    tag_t            w_last;
    logic [R-1:0]    w_rsp_onehot;
    logic            w_busy;

    logic [R-1:0]    r_rsp_valid;
    logic [N-1:0]    r_rsp_sum;
    logic            r_rsp_carry;

    // Gating with ResetN keeps ReqReady low while reset is asserted.
    assign w_enable = ResetN & ~Drain;

    rr_arbiter #(
        .R(R)
    ) u_arb (
        .clk        (Clock),
        .rst_n      (ResetN),
        .i_req      (ReqValid),
        .i_enable   (w_enable),
        .o_grant    (w_grant),
        .o_grant_id (w_grant_id),
        .o_accept   (w_accept)
    );

    assign ReqReady = w_grant;

    always_comb begin
        w_sel_a  = '0;
        w_sel_b  = '0;
        w_sel_ci = 1'b0;
        w_sel_op = OP_ADD;
        for (int unsigned i = 0; i < R; i++) begin
            if (w_grant[i]) begin
                w_sel_a  = ReqA[i*N +: N];
                w_sel_b  = ReqB[i*N +: N];
                w_sel_ci = ReqCI[i];
                w_sel_op = op_e'(ReqOp[i]);
            end
        end
    end

    // Subtraction as A + ~B + 1, so the adder carry-out is the not-borrow.
    always_comb begin
        w_opnd_b  = w_sel_b;
        w_opnd_ci = w_sel_ci;
        if (w_sel_op == OP_SUB) begin
            w_opnd_b  = ~w_sel_b;
            w_opnd_ci = 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_add_a  <= '0;
            r_add_b  <= '0;
            r_add_ci <= 1'b0;
        end else if (w_accept) begin
            r_add_a  <= w_sel_a;
            r_add_b  <= w_opnd_b;
            r_add_ci <= w_opnd_ci;
        end
    end

    assign AddA  = r_add_a;
    assign AddB  = r_add_b;
    assign AddCI = r_add_ci;

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            for (int unsigned i = 0; i < LAT; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0] <= '{valid: w_accept, id: w_grant_id};
            for (int unsigned i = 1; i < LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign w_last       = r_tag[LAT-1];
    assign w_rsp_onehot = R'(1) << w_last.id;

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_rsp_valid <= '0;
            r_rsp_sum   <= '0;
            r_rsp_carry <= 1'b0;
        end else if (w_last.valid) begin
            r_rsp_valid <= w_rsp_onehot;
            r_rsp_sum   <= AddS;
            r_rsp_carry <= AddCO;
        end else begin
            r_rsp_valid <= '0;
        end
    end

    assign RspValid = r_rsp_valid;
    assign RspSum   = r_rsp_sum;
    assign RspCarry = r_rsp_carry;

    always_comb begin
        w_busy = 1'b0;
        for (int unsigned i = 0; i < LAT; i++) begin
            w_busy = w_busy | r_tag[i].valid;
        end
    end

    assign Idle = ~w_busy;

endmodule

// File: tb/tb_staggered_add_sched.sv
// Scoreboard bench for staggered_add_sched with a behavioural LAT-cycle adder.
module tb_staggered_add_sched;

    localparam int N   = 16;
    localparam int R   = 4;
    localparam int LAT = 4;

    logic           Clock = 1'b0;
    logic           ResetN;
    logic [R-1:0]   ReqValid;
    logic [R-1:0]   ReqReady;
    logic [R*N-1:0] ReqA;
    logic [R*N-1:0] ReqB;
    logic [R-1:0]   ReqCI;
    logic [R-1:0]   ReqOp;
    logic [N-1:0]   AddA;
    logic [N-1:0]   AddB;
    logic           AddCI;
    logic [N-1:0]   AddS;
    logic           AddCO;
    logic [R-1:0]   RspValid;
    logic [N-1:0]   RspSum;
    logic           RspCarry;
    logic           Drain;
    logic           Idle;

    staggered_add_sched #(
        .N   (N),
        .R   (R),
        .LAT (LAT)
    ) dut (
        .Clock    (Clock),
        .ResetN   (ResetN),
        .ReqValid (ReqValid),
        .ReqReady (ReqReady),
        .ReqA     (ReqA),
        .ReqB     (ReqB),
        .ReqCI    (ReqCI),
        .ReqOp    (ReqOp),
        .AddA     (AddA),
        .AddB     (AddB),
        .AddCI    (AddCI),
        .AddS     (AddS),
        .AddCO    (AddCO),
        .RspValid (RspValid),
        .RspSum   (RspSum),
        .RspCarry (RspCarry),
        .Drain    (Drain),
        .Idle     (Idle)
    );

    always #5 Clock = ~Clock;

    // Adder model: result visible LAT cycles after the operand register update.
    logic [N:0] m_pipe [LAT-1];
    always @(posedge Clock) begin
        m_pipe[0] <= {1'b0, AddA} + {1'b0, AddB} + (N+1)'(AddCI);
        for (int i = 1; i < LAT - 1; i++) m_pipe[i] <= m_pipe[i-1];
    end
    assign AddS  = m_pipe[LAT-2][N-1:0];
    assign AddCO = m_pipe[LAT-2][N];

    typedef struct {
        int         id;
        logic [N:0] res;
        int         cyc;
    } exp_t;

    exp_t         sb[$];
    int           gnt_log[$];
    int           n_cmp = 0;
    int           n_err = 0;
    int           cyc = 0;
    int           m_ptr = 0;
    int           gnt_cnt = 0;
    int           last_gnt_cyc = 0;
    logic [R-1:0] last_gnt = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N:0] ref_res(input int i);
        logic [N-1:0] a;
        logic [N-1:0] b;
        a = ReqA[i*N +: N];
        b = ReqB[i*N +: N];
        if (ReqOp[i]) return {(a >= b), N'(a - b)};
        return (N+1)'(a) + (N+1)'(b) + (N+1)'(ReqCI[i]);
    endfunction

    function automatic logic [R-1:0] exp_ready();
        int idx;
        if (!ResetN || Drain) return '0;
        for (int k = 0; k < R; k++) begin
            idx = (m_ptr + k) % R;
            if (ReqValid[idx]) return R'(1) << idx;
        end
        return '0;
    endfunction

    always @(posedge Clock) cyc <= cyc + 1;

    always @(negedge Clock) begin
        exp_t e;
        if (!ResetN) m_ptr = 0;
        check_eq("ready", 32'(ReqReady), 32'(exp_ready()));
        last_gnt = ReqValid & ReqReady;
        for (int i = 0; i < R; i++) begin
            if (last_gnt[i]) begin
                sb.push_back('{id: i, res: ref_res(i), cyc: cyc});
                gnt_log.push_back(i);
                m_ptr = (i + 1) % R;
                gnt_cnt++;
                last_gnt_cyc = cyc;
            end
        end
        if (RspValid != '0) begin
            if (sb.size() == 0) begin
                check_eq("rsp_unexpected", 32'(RspValid), 32'd0);
            end else begin
                e = sb.pop_front();
                check_eq("rsp_id", 32'(RspValid), 32'(R'(1) << e.id));
                check_eq("rsp_val", 32'({RspCarry, RspSum}), 32'(e.res));
                check_eq("rsp_lat", 32'(cyc - e.cyc), 32'(LAT + 1));
            end
        end
    end

    task automatic do_req(input int id, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic ci, input logic op);
        bit ok;
        @(posedge Clock); #1;
        ReqA[id*N +: N] = a;
        ReqB[id*N +: N] = b;
        ReqCI[id]       = ci;
        ReqOp[id]       = op;
        ReqValid[id]    = 1'b1;
        ok = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge Clock);
            if (ReqReady[id]) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check_eq("req_timeout", 32'd0, 32'd1);
        @(posedge Clock); #1;
        ReqValid[id] = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge Clock); #1;
            if (Idle && sb.size() == 0) begin
                ok = 1;
                break;
            end
        end
        check_eq("idle_wait", 32'(ok), 32'd1);
    endtask

    task automatic apply_reset();
        @(posedge Clock); #1;
        ResetN = 1'b0;
        sb.delete();
        repeat (2) @(posedge Clock);
        #1 ResetN = 1'b1;
    endtask

    initial begin
        int base;
        int lastc;
        int ops;
        int budget;
        bit ok;

        ResetN   = 1'b0;
        ReqValid = '1;
        ReqA     = '0;
        ReqB     = '0;
        ReqCI    = '0;
        ReqOp    = '0;
        Drain    = 1'b0;
        #1;
        check_eq("rst_ready", 32'(ReqReady), 32'd0);
        check_eq("rst_idle", 32'(Idle), 32'd1);
        check_eq("rst_add", 32'({AddCI, AddA, AddB}), 32'd0);
        check_eq("rst_rsp", 32'({RspValid, RspCarry, RspSum}), 32'd0);
        ReqValid = '0;
        repeat (3) @(posedge Clock);
        #1 ResetN = 1'b1;

        do_req(0, 16'd7, 16'd9, 1'b1, 1'b0);
        wait_idle();
        check_eq("add_7_9_1", 32'({RspCarry, RspSum}), 32'h00011);

        do_req(2, 16'd5, 16'd9, 1'b0, 1'b1);
        wait_idle();
        check_eq("sub_5_9", 32'({RspCarry, RspSum}), 32'h0FFFC);
        do_req(2, 16'd9, 16'd5, 1'b1, 1'b1);
        wait_idle();
        check_eq("sub_9_5", 32'({RspCarry, RspSum}), 32'h10004);

        do_req(3, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        wait_idle();
        check_eq("add_wrap", 32'({RspCarry, RspSum}), 32'h10000);

        // All four requesting continuously for 8 cycles from a reset pointer.
        apply_reset();
        gnt_log.delete();
        for (int i = 0; i < R; i++) begin
            ReqA[i*N +: N] = N'(100 * (i + 1));
            ReqB[i*N +: N] = N'(i + 3);
            ReqOp[i]       = i[0];
            ReqCI[i]       = 1'b1;
        end
        @(posedge Clock); #1;
        ReqValid = '1;
        repeat (8) @(posedge Clock);
        #1 ReqValid = '0;
        check_eq("rr_count", 32'(gnt_log.size()), 32'd8);
        for (int j = 0; j < 8; j++) begin
            if (j < gnt_log.size()) check_eq("rr_order", 32'(gnt_log[j]), 32'(j % R));
        end
        wait_idle();

        // Drain after three grants with requests still pending.
        base = gnt_cnt;
        ReqValid = '1;
        ok = 0;
        for (int k = 0; k < 50; k++) begin
            @(posedge Clock); #1;
            if (gnt_cnt - base >= 3) begin
                ok = 1;
                break;
            end
        end
        Drain = 1'b1;
        check_eq("drain_wait", 32'(ok), 32'd1);
        lastc = last_gnt_cyc;
        ok = 0;
        for (int k = 0; k < 50; k++) begin
            @(posedge Clock); #1;
            check_eq("drain_rdy", 32'(ReqReady), 32'd0);
            if (Idle) begin
                ok = 1;
                break;
            end
        end
        check_eq("drain_idle", 32'(ok), 32'd1);
        check_eq("idle_lat", 32'(cyc - lastc), 32'(LAT + 1));
        @(posedge Clock); #1;
        check_eq("drain_grants", 32'(gnt_cnt - base), 32'd3);
        check_eq("drain_delivered", 32'(sb.size()), 32'd0);
        ReqValid = '0;
        Drain    = 1'b0;

        // Reset two cycles after a grant discards the in-flight result.
        do_req(1, 16'h1234, 16'h0F0F, 1'b0, 1'b0);
        @(posedge Clock); #1;
        ReqValid[1] = 1'b1;
        ResetN      = 1'b0;
        sb.delete();
        #1;
        check_eq("mid_rst_ready", 32'(ReqReady), 32'd0);
        check_eq("mid_rst_idle", 32'(Idle), 32'd1);
        check_eq("mid_rst_add", 32'({AddCI, AddA, AddB}), 32'd0);
        check_eq("mid_rst_rsp", 32'({RspValid, RspCarry, RspSum}), 32'd0);
        repeat (3) @(posedge Clock);
        #1 ReqValid = '0;
        ResetN = 1'b1;
        repeat (10) @(posedge Clock);
        do_req(1, 16'h8000, 16'h8001, 1'b1, 1'b0);
        wait_idle();
        check_eq("post_rst_add", 32'({RspCarry, RspSum}), 32'h10002);

        // Random traffic with occasional drain.
        base   = gnt_cnt;
        ops    = 0;
        budget = 0;
        while (ops < 10000 && budget < 60000) begin
            @(posedge Clock); #1;
            for (int i = 0; i < R; i++) begin
                if (last_gnt[i]) ReqValid[i] = 1'b0;
                if (!ReqValid[i] && ($urandom_range(0, 1) == 1)) begin
                    ReqA[i*N +: N] = N'($urandom);
                    ReqB[i*N +: N] = N'($urandom);
                    ReqCI[i]       = 1'($urandom);
                    ReqOp[i]       = 1'($urandom);
                    ReqValid[i]    = 1'b1;
                end
            end
            Drain = ($urandom_range(0, 7) == 0);
            ops = gnt_cnt - base;
            budget++;
        end
        ReqValid = '0;
        Drain    = 1'b0;
        check_eq("rand_ops_done", 32'(ops >= 10000), 32'd1);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
